// File: rtl/sprite_damage_writer.sv
// sprite_damage_writer: stamps an erase mask into a sprite bitmap RAM around a hit point
module sprite_damage_writer #(
    parameter int WIDTH        = 22,
    parameter int HEIGHT       = 16,
    parameter int SCALE        = 1,
    parameter int SCREEN_CORDW = 16,
    parameter int COLR_BITS    = 4,
    parameter int STAMP_W      = 4,
    parameter int STAMP_H      = 4,
    parameter logic [STAMP_W*STAMP_H-1:0] STAMP_MASK = 16'h6FF6
) (
    input  logic                                   clk_pix,
    input  logic                                   rst,
    input  logic                                   hit_valid,
    output logic                                   hit_ready,
    input  logic signed [SCREEN_CORDW-1:0]         hit_x,
    input  logic signed [SCREEN_CORDW-1:0]         hit_y,
    input  logic signed [SCREEN_CORDW-1:0]         sprite_x,
    input  logic signed [SCREEN_CORDW-1:0]         sprite_y,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]        mem_addr,
    output logic                                   mem_we,
    output logic [COLR_BITS-1:0]                   mem_wdata,
    input  logic [COLR_BITS-1:0]                   mem_rdata,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(STAMP_W*STAMP_H+1)-1:0]   erased_cnt
);
    localparam int N  = SCREEN_CORDW + 1;
    localparam int AW = $clog2(WIDTH*HEIGHT);
    localparam int CW = $clog2(STAMP_W+1);
    localparam int RW = $clog2(STAMP_H+1);
    localparam int KW = $clog2(STAMP_W*STAMP_H);
    localparam int SH = $clog2(SCALE);
    localparam int EW = $clog2(STAMP_W*STAMP_H+1);

    typedef enum logic [2:0] {IDLE, SETUP, CHECK, RDATA, WRITE, DONE} state_t;

    state_t              r_state, w_next;
    logic signed [N-1:0] r_dx, r_dy, r_ox, r_oy, w_x, w_y;
    logic [CW-1:0]       r_c;
    logic [RW-1:0]       r_r;
    logic [KW-1:0]       r_k;
    logic [EW-1:0]       r_cnt;
    logic [AW-1:0]       w_addr;
    logic                w_in, w_hit, w_last, w_adv, w_eol;

    assign w_x    = r_ox + $signed(N'(r_c));
    assign w_y    = r_oy + $signed(N'(r_r));
    assign w_in   = !w_x[N-1] && w_x < $signed(N'(WIDTH)) && !w_y[N-1] && w_y < $signed(N'(HEIGHT));
    assign w_hit  = STAMP_MASK[r_k] && w_in;
    assign w_last = r_k == KW'(STAMP_W*STAMP_H-1);
    assign w_eol  = r_c == CW'(STAMP_W-1);
    assign w_addr = w_y[AW-1:0] * AW'(WIDTH) + w_x[AW-1:0];
    assign w_adv  = (r_state == CHECK && !w_hit) || (r_state == RDATA && mem_rdata == '0) || r_state == WRITE;

    assign hit_ready  = r_state == IDLE && !rst;
    assign busy       = r_state != IDLE;
    assign done       = r_state == DONE;
    assign mem_we     = r_state == WRITE;
    assign mem_wdata  = '0;
    assign erased_cnt = r_cnt;
    // Address is only presented while a live cell is being read or written.
    assign mem_addr   = ((r_state == CHECK && w_hit) || r_state == RDATA || r_state == WRITE) ? w_addr : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = hit_valid ? SETUP : IDLE;
            SETUP:   w_next = CHECK;
            CHECK:   w_next = w_hit ? RDATA : (w_last ? DONE : CHECK);
            RDATA:   w_next = mem_rdata != '0 ? WRITE : (w_last ? DONE : CHECK);
            WRITE:   w_next = w_last ? DONE : CHECK;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (hit_valid && hit_ready) begin
                r_dx <= {hit_x[SCREEN_CORDW-1], hit_x} - {sprite_x[SCREEN_CORDW-1], sprite_x};
                r_dy <= {hit_y[SCREEN_CORDW-1], hit_y} - {sprite_y[SCREEN_CORDW-1], sprite_y};
            end
            if (r_state == SETUP) begin
                r_ox  <= (r_dx >>> SH) - $signed(N'(STAMP_W/2));
                r_oy  <= (r_dy >>> SH) - $signed(N'(STAMP_H/2));
                r_cnt <= '0;
                r_c   <= '0;
                r_r   <= '0;
                r_k   <= '0;
            end
            if (r_state == WRITE) r_cnt <= r_cnt + 1'b1;
            if (w_adv) begin
                r_c <= w_eol ? '0 : r_c + 1'b1;
                r_r <= r_r + RW'(w_eol);
                r_k <= r_k + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sprite_damage_writer.sv
// tb_sprite_damage_writer: directed hits checked cycle by cycle against a behavioural stamp model
module tb_sprite_damage_writer;
    localparam int W = 22, H = 16, NPIX = W*H;
    localparam logic [15:0] MASK = 16'h6FF6;

    logic clk_pix = 0, rst = 1, hit_valid = 0;
    logic signed [15:0] hit_x = 0, hit_y = 0, sprite_x = 0, sprite_y = 0;
    int sel = 0;
    int tests = 0, fails = 0;

    logic v1, v2, rdy1, rdy2, we1, we2, busy1, busy2, done1, done2;
    logic [8:0] a1, a2;
    logic [3:0] wd1, wd2, rd1, rd2;
    logic [4:0] ec1, ec2;
    logic m_rdy, m_we, m_busy, m_done;
    logic [8:0] m_addr;
    logic [3:0] m_wd;
    logic [4:0] m_cnt;

    logic [3:0] ram1 [NPIX];
    logic [3:0] ram2 [NPIX];
    int img1 [NPIX];
    int img2 [NPIX];
    int tr_we[$], tr_addr[$], got_addr[$];
    int exp_cnt;

    assign v1 = hit_valid && sel == 0;
    assign v2 = hit_valid && sel == 1;
    assign m_rdy  = sel == 1 ? rdy2  : rdy1;
    assign m_we   = sel == 1 ? we2   : we1;
    assign m_busy = sel == 1 ? busy2 : busy1;
    assign m_done = sel == 1 ? done2 : done1;
    assign m_addr = sel == 1 ? a2    : a1;
    assign m_wd   = sel == 1 ? wd2   : wd1;
    assign m_cnt  = sel == 1 ? ec2   : ec1;

    sprite_damage_writer #(.SCALE(1)) dut (
        .clk_pix(clk_pix), .rst(rst), .hit_valid(v1), .hit_ready(rdy1),
        .hit_x(hit_x), .hit_y(hit_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .mem_addr(a1), .mem_we(we1), .mem_wdata(wd1), .mem_rdata(rd1),
        .busy(busy1), .done(done1), .erased_cnt(ec1));

    sprite_damage_writer #(.SCALE(2)) dut2 (
        .clk_pix(clk_pix), .rst(rst), .hit_valid(v2), .hit_ready(rdy2),
        .hit_x(hit_x), .hit_y(hit_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .mem_addr(a2), .mem_we(we2), .mem_wdata(wd2), .mem_rdata(rd2),
        .busy(busy2), .done(done2), .erased_cnt(ec2));

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) begin
        rd1 <= int'(a1) < NPIX ? ram1[a1] : 4'h0;
        rd2 <= int'(a2) < NPIX ? ram2[a2] : 4'h0;
        if (we1 && int'(a1) < NPIX) ram1[a1] <= wd1;
        if (we2 && int'(a2) < NPIX) ram2[a2] <= wd2;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int floor_div(input int d, input int s);
        return d >= 0 ? d / s : -((-d + s - 1) / s);
    endfunction

    // Per-cell trace of mem_we after SETUP, taken straight from the erosion rules.
    task automatic model(input int hx, input int hy, input int sx, input int sy, input int s);
        int ox, oy, x, y, a, v;
        tr_we.delete();
        tr_addr.delete();
        exp_cnt = 0;
        ox = floor_div(hx - sx, s == 1 ? 2 : 1) - 2;
        oy = floor_div(hy - sy, s == 1 ? 2 : 1) - 2;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                x = ox + c;
                y = oy + r;
                if (!MASK[r*4+c] || x < 0 || x >= W || y < 0 || y >= H) begin
                    tr_we.push_back(0); tr_addr.push_back(0);
                end else begin
                    a = y*W + x;
                    v = s == 1 ? img2[a] : img1[a];
                    tr_we.push_back(0); tr_addr.push_back(a);
                    tr_we.push_back(0); tr_addr.push_back(a);
                    if (v != 0) begin
                        tr_we.push_back(1); tr_addr.push_back(a);
                        exp_cnt++;
                        if (s == 1) img2[a] = 0; else img1[a] = 0;
                    end
                end
            end
    endtask

    task automatic run(input int s, input int hx, input int hy, input int sx, input int sy,
                       input int pulse, output int dcyc);
        int len, bad;
        model(hx, hy, sx, sy, s);
        len = tr_we.size();
        sel = s;
        got_addr.delete();
        dcyc = -1;
        @(negedge clk_pix);
        chk("ready_idle", m_rdy, 1);
        hit_x = 16'(hx); hit_y = 16'(hy); sprite_x = 16'(sx); sprite_y = 16'(sy);
        hit_valid = 1;
        @(negedge clk_pix);
        hit_valid = 0;
        for (int cyc = 1; cyc <= len + 2; cyc++) begin
            chk("busy", m_busy, 1);
            chk("we", m_we, (cyc >= 2 && cyc <= len + 1) ? tr_we[cyc-2] : 0);
            if (m_we && cyc >= 2 && cyc <= len + 1) begin
                chk("addr", m_addr, tr_addr[cyc-2]);
                chk("wdata", m_wd, 0);
                got_addr.push_back(int'(m_addr));
            end
            chk("done", m_done, int'(cyc == len + 2));
            if (m_done && dcyc < 0) dcyc = cyc;
            hit_valid = cyc == pulse;
            if (cyc < len + 2) @(negedge clk_pix);
        end
        hit_valid = 0;
        chk("erased_cnt", m_cnt, exp_cnt);
        @(negedge clk_pix);
        chk("idle_busy", m_busy, 0);
        chk("idle_ready", m_rdy, 1);
        chk("idle_done", m_done, 0);
        chk("cnt_held", m_cnt, exp_cnt);
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (int'(s == 1 ? ram2[i] : ram1[i]) != (s == 1 ? img2[i] : img1[i])) bad++;
        chk("ram_image", bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: no finish after %0t", $time);
        $fatal(1);
    end

    initial begin
        int d, k, q;
        int t3[3] = '{0, 1, 22};
        for (int i = 0; i < NPIX; i++) begin
            ram1[i] = 4'h3; ram2[i] = 4'h3; img1[i] = 3; img2[i] = 3;
        end
        repeat (3) @(negedge clk_pix);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_we", we1, 0);
        chk("rst_addr", a1, 0);
        chk("rst_cnt", ec1, 0);
        chk("rst_ready", rdy1, 0);
        rst = 0;
        @(negedge clk_pix);
        chk("ready_after_rst", rdy1, 1);

        run(0, 110, 208, 100, 200, 0, d);
        chk("t1_model_len", tr_we.size() + 2, 42);
        chk("t1_model_cnt", exp_cnt, 12);
        chk("t1_done_cycle", d, 42);
        chk("t1_writes", got_addr.size(), 12);
        chk("t1_first_addr", got_addr.size() > 0 ? got_addr[0] : -1, 141);
        chk("t1_cnt", ec1, 12);

        run(0, 110, 208, 100, 200, 0, d);
        chk("t2_done_cycle", d, 30);
        chk("t2_writes", got_addr.size(), 0);
        chk("t2_cnt", ec1, 0);

        run(0, 100, 200, 100, 200, 0, d);
        chk("t3_writes", got_addr.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("t3_addr", i < got_addr.size() ? got_addr[i] : -1, t3[i]);
        chk("t3_cnt", ec1, 3);

        run(0, 50, 50, 100, 200, 0, d);
        chk("t4_done_cycle", d, 18);
        chk("t4_writes", got_addr.size(), 0);
        chk("t4_cnt", ec1, 0);

        run(1, 121, 217, 100, 200, 10, d);
        chk("t5_done_cycle", d, 42);
        chk("t5_writes", got_addr.size(), 12);
        chk("t5_first_addr", got_addr.size() > 0 ? got_addr[0] : -1, 141);
        chk("t5_cnt", ec2, 12);

        sel = 0;
        @(negedge clk_pix);
        hit_x = 115; hit_y = 212; sprite_x = 100; sprite_y = 200;
        hit_valid = 1;
        @(negedge clk_pix);
        hit_valid = 0;
        k = 0;
        while (!we1 && k < 60) begin
            @(negedge clk_pix);
            k++;
        end
        chk("t6_reached_write", we1, 1);
        chk("t6_write_addr", a1, 234);
        img1[234] = 0;
        rst = 1;
        @(negedge clk_pix);
        chk("t6_we", we1, 0);
        chk("t6_busy", busy1, 0);
        chk("t6_done", done1, 0);
        chk("t6_addr", a1, 0);
        chk("t6_cnt", ec1, 0);
        chk("t6_ready_in_rst", rdy1, 0);
        rst = 0;
        @(negedge clk_pix);
        chk("t6_ready_after", rdy1, 1);
        q = 0;
        repeat (5) begin
            @(negedge clk_pix);
            if (we1 || busy1) q++;
        end
        chk("t6_quiet", q, 0);

        run(0, 50, 50, 100, 200, 0, d);
        chk("t7_done_cycle", d, 18);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
